// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_BLOCK = 4;

  // Carry injected into group 0 when subtracting (a + ~b + 1)
  localparam logic SUB_CIN = 1'b1;

  // Number of lookahead groups, which is also the pipeline depth
  function automatic int unsigned nblk(input int unsigned width, input int unsigned block);
    return width / block;
  endfunction

endpackage

// File: rtl/cla_block.sv
// One BLOCK-bit carry-lookahead group: every internal carry is a flat
// sum of products of generate/propagate terms, with no bit-to-bit ripple.
module cla_block
  import cla_pkg::*;
#(
  parameter int unsigned BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  input  logic             i_ci,
  output logic [BLOCK-1:0] o_s,
  output logic             o_co,
  output logic             o_p,
  output logic             o_g
);

  logic [BLOCK-1:0] w_g;
  logic [BLOCK-1:0] w_p;
  logic [BLOCK:0]   w_c;
  logic             w_term;
  logic             w_gterm;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Carry into bit i+1: ci*p[0..i] | g[j]*p[j+1..i] for every j <= i
  always_comb begin
    w_c    = '0;
    w_term = 1'b0;
    w_c[0] = i_ci;
    for (int i = 0; i < int'(BLOCK); i++) begin
      w_term = i_ci;
      for (int m = 0; m <= i; m++) begin
        w_term = w_term & w_p[m];
      end
      w_c[i+1] = w_term;
      for (int j = 0; j <= i; j++) begin
        w_term = w_g[j];
        for (int m = j + 1; m <= i; m++) begin
          w_term = w_term & w_p[m];
        end
        w_c[i+1] = w_c[i+1] | w_term;
      end
    end
  end

  // Group generate: some bit generates and every bit above it propagates
  always_comb begin
    o_g     = 1'b0;
    w_gterm = 1'b0;
    for (int j = 0; j < int'(BLOCK); j++) begin
      w_gterm = w_g[j];
      for (int m = j + 1; m < int'(BLOCK); m++) begin
        w_gterm = w_gterm & w_p[m];
      end
      o_g = o_g | w_gterm;
    end
  end

  assign o_p  = &w_p;
  assign o_s  = w_p ^ w_c[BLOCK-1:0];
  assign o_co = w_c[BLOCK];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor. One BLOCK-bit group is
// resolved per stage; the group carry and the still-unprocessed upper
// operand bits travel forward with the partial sum.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NBLK = nblk(WIDTH, BLOCK);

  if ((BLOCK == 0) || (WIDTH < BLOCK) || ((WIDTH % BLOCK) != 0)) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH (%0d) must be a nonzero multiple of BLOCK (%0d)", WIDTH, BLOCK);
  end

  // Stage registers; r_a/r_b hold operand bits already shifted down so the
  // next group to resolve always sits in the low BLOCK bits
  logic             r_vld [NBLK];
  logic [WIDTH-1:0] r_sum [NBLK];
  logic             r_c   [NBLK];
  logic [WIDTH-1:0] r_a   [NBLK];
  logic [WIDTH-1:0] r_b   [NBLK];
  logic             r_as  [NBLK];
  logic             r_bs  [NBLK];
  logic             r_ovf;
  logic             r_zero;

  // Values presented to each stage's register inputs
  logic             w_vin  [NBLK];
  logic [WIDTH-1:0] w_opa  [NBLK];
  logic [WIDTH-1:0] w_opb  [NBLK];
  logic [WIDTH-1:0] w_lo   [NBLK];
  logic             w_ci   [NBLK];
  logic             w_as   [NBLK];
  logic             w_bs   [NBLK];
  logic [BLOCK-1:0] w_gs   [NBLK];
  logic             w_gco  [NBLK];
  logic             w_gp   [NBLK];
  logic             w_gg   [NBLK];
  logic [WIDTH-1:0] w_nsum [NBLK];
  logic             w_adv;

  // Whole pipe moves only when the output slot is empty or being drained
  assign w_adv = !r_vld[NBLK-1] || out_ready;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Stage 0 takes fresh operands; b is inverted once here for subtract
      assign w_vin[k] = in_valid;
      assign w_opa[k] = a;
      assign w_opb[k] = sub ? ~b : b;
      assign w_lo[k]  = '0;
      assign w_ci[k]  = sub ? SUB_CIN : cin;
      assign w_as[k]  = a[WIDTH-1];
      assign w_bs[k]  = w_opb[k][WIDTH-1];
    end else begin : g_body
      // Later stages continue from what the previous stage registered
      assign w_vin[k] = r_vld[k-1];
      assign w_opa[k] = r_a[k-1];
      assign w_opb[k] = r_b[k-1];
      assign w_lo[k]  = r_sum[k-1];
      assign w_ci[k]  = r_c[k-1];
      assign w_as[k]  = r_as[k-1];
      assign w_bs[k]  = r_bs[k-1];
    end

    cla_block #(
      .BLOCK (BLOCK)
    ) u_blk (
      .i_a  (w_opa[k][BLOCK-1:0]),
      .i_b  (w_opb[k][BLOCK-1:0]),
      .i_ci (w_ci[k]),
      .o_s  (w_gs[k]),
      .o_co (w_gco[k]),
      .o_p  (w_gp[k]),
      .o_g  (w_gg[k])
    );

    // Merge this group's sum bits above the bits already resolved
    assign w_nsum[k] = w_lo[k] | (WIDTH'(w_gs[k]) << (k * BLOCK));

    // Group-level lookahead must agree with the group's own carry chain
    assert property (@(posedge clk) disable iff (!rst_n)
      w_gco[k] == (w_gg[k] | (w_gp[k] & w_ci[k])));
  end

  // Shift all stages together; payload only loads behind a valid bit so
  // bubbles and idle inputs never disturb held data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NBLK); k++) begin
        r_vld[k] <= 1'b0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_as[k]  <= 1'b0;
        r_bs[k]  <= 1'b0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < int'(NBLK); k++) begin
        r_vld[k] <= w_vin[k];
        if (w_vin[k]) begin
          r_sum[k] <= w_nsum[k];
          r_c[k]   <= w_gco[k];
          r_a[k]   <= w_opa[k] >> BLOCK;
          r_b[k]   <= w_opb[k] >> BLOCK;
          r_as[k]  <= w_as[k];
          r_bs[k]  <= w_bs[k];
        end
      end
      if (w_vin[NBLK-1]) begin
        r_ovf  <= (w_as[NBLK-1] == w_bs[NBLK-1]) &&
                  (w_nsum[NBLK-1][WIDTH-1] != w_as[NBLK-1]);
        r_zero <= ~|w_nsum[NBLK-1];
      end
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_vld[NBLK-1];
  assign sum       = r_sum[NBLK-1];
  assign cout      = r_c[NBLK-1];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: three configurations (8/4, 32/8, 4/4) share one
// stimulus stream; each has its own scoreboard fed by an arithmetic model.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;

  logic       rdy0, ov0, c0, o0, z0;
  logic [7:0] s0;
  logic        rdy1, ov1, c1, o1, z1;
  logic [31:0] s1;
  logic       rdy2, ov2, c2, o2, z2;
  logic [3:0] s2;

  int n_chk = 0;
  int n_pass = 0;
  int cnt0 = 0, cnt1 = 0, cnt2 = 0;
  int stall_cnt = 0;
  logic [35:0] q0[$];
  logic [35:0] q1[$];
  logic [35:0] q2[$];

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(8), .BLOCK(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(c0), .ovf(o0), .zero(z0));

  cla_pipe_adder #(.WIDTH(32), .BLOCK(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .a(a_in), .b(b_in), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(c1), .ovf(o1), .zero(z1));

  cla_pipe_adder #(.WIDTH(4), .BLOCK(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .a(a_in[3:0]), .b(b_in[3:0]), .cin(cin), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(c2), .ovf(o2), .zero(z2));

  function automatic void chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %09h want %09h", name, act, exp);
  endfunction

  function automatic void bad(input string name);
    n_chk++;
    $display("FAIL %s: unexpected event", name);
  endfunction

  // Reference: plain integer arithmetic; returns {zero, ovf, cout, sum}
  function automatic logic [35:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb);
    longint m, half, ua, ub, full, sa, sbv, res;
    logic [31:0] s;
    logic cy, ov, zr;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    if (sb) full = ua - ub + (m + 1);
    else    full = ua + ub + longint'(ci);
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sbv  = (ub >= half) ? ub - (m + 1) : ub;
    res  = sb ? (sa - sbv) : (sa + sbv + longint'(ci));
    ov   = (res >= half) || (res < -half);
    s    = 32'(full & m);
    cy   = ((full >> w) & 1) != 0;
    zr   = (s == 32'd0);
    return {zr, ov, cy, s};
  endfunction

  // Queue expected results on accept, compare on drain (pre-edge state)
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && !(rdy0 && rdy1 && rdy2)) stall_cnt++;
      if (in_valid && rdy0) q0.push_back(model(8, a_in, b_in, cin, sub));
      if (in_valid && rdy1) q1.push_back(model(32, a_in, b_in, cin, sub));
      if (in_valid && rdy2) q2.push_back(model(4, a_in, b_in, cin, sub));
      if (ov0 && out_ready) begin
        cnt0++;
        if (q0.size() == 0) bad("sb0_extra");
        else chk("sb0", {z0, o0, c0, 32'(s0)}, q0.pop_front());
      end
      if (ov1 && out_ready) begin
        cnt1++;
        if (q1.size() == 0) bad("sb1_extra");
        else chk("sb1", {z1, o1, c1, s1}, q1.pop_front());
      end
      if (ov2 && out_ready) begin
        cnt2++;
        if (q2.size() == 0) bad("sb2_extra");
        else chk("sb2", {z2, o2, c2, 32'(s2)}, q2.pop_front());
      end
    end
  end

  // Reset discards everything in flight
  always @(negedge rst_n) begin
    q0.delete();
    q1.delete();
    q2.delete();
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
    a_in = a; b_in = b; cin = ci; sub = sb; in_valid = 1'b1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vt[10];
  logic [31:0] ta[3];
  logic [31:0] tbv[3];
  int base0, base1, base2, gap0, gap1, gap2, stale;

  initial begin
    vt[0] = '{8'd200, 8'd100, 1'b0, 1'b0, 8'd44,  1'b1, 1'b0, 1'b0};
    vt[1] = '{8'd5,   8'd7,   1'b1, 1'b1, 8'd254, 1'b0, 1'b0, 1'b0};
    vt[2] = '{8'd7,   8'd5,   1'b1, 1'b1, 8'd2,   1'b1, 1'b0, 1'b0};
    vt[3] = '{8'd127, 8'd1,   1'b0, 1'b0, 8'd128, 1'b0, 1'b1, 1'b0};
    vt[4] = '{8'd128, 8'd1,   1'b0, 1'b1, 8'd127, 1'b1, 1'b1, 1'b0};
    vt[5] = '{8'd255, 8'd1,   1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1};
    vt[6] = '{8'd0,   8'd0,   1'b0, 1'b1, 8'd0,   1'b1, 1'b0, 1'b1};
    vt[7] = '{8'd100, 8'd27,  1'b1, 1'b0, 8'd128, 1'b0, 1'b1, 1'b0};
    vt[8] = '{8'd15,  8'd1,   1'b0, 1'b0, 8'd16,  1'b0, 1'b0, 1'b0};
    vt[9] = '{8'd255, 8'd0,   1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1};

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 36'({ov0, ov1, ov2}), 36'd0);
    chk("rst_payload0", {z0, o0, c0, 32'(s0)}, 36'd0);
    chk("rst_payload1", {z1, o1, c1, s1}, 36'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 36'({rdy0, rdy1, rdy2}), 36'h7);
    chk("idle_out_valid", 36'({ov0, ov1, ov2}), 36'd0);

    // Directed vectors on the 8/4 instance: exact 2-cycle latency
    for (int i = 0; i < 10; i++) begin
      drive(32'(vt[i].a), 32'(vt[i].b), vt[i].cin, vt[i].sub);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_lat1", i), 36'(ov0), 36'd0);
      tick();
      chk($sformatf("vec%0d_lat2", i), 36'(ov0), 36'd1);
      chk($sformatf("vec%0d_res", i), {z0, o0, c0, 32'(s0)},
          {vt[i].zero, vt[i].ovf, vt[i].cout, 32'(vt[i].sum)});
      tick();
    end
    repeat (4) tick();

    // Backpressure: three adds offered while the consumer stalls
    for (int i = 0; i < 3; i++) begin
      ta[i]  = $urandom;
      tbv[i] = $urandom;
    end
    out_ready = 1'b0;
    base0 = cnt0;
    drive(ta[0], tbv[0], 1'b1, 1'b0);
    tick();
    drive(ta[1], tbv[1], 1'b0, 1'b0);
    tick();
    drive(ta[2], tbv[2], 1'b1, 1'b0);
    chk("bp_out_valid", 36'(ov0), 36'd1);
    chk("bp_in_ready", 36'(rdy0), 36'd0);
    chk("bp_first", {z0, o0, c0, 32'(s0)}, model(8, ta[0], tbv[0], 1'b1, 1'b0));
    repeat (3) tick();
    chk("bp_hold_valid", 36'(ov0), 36'd1);
    chk("bp_hold", {z0, o0, c0, 32'(s0)}, model(8, ta[0], tbv[0], 1'b1, 1'b0));
    chk("bp_in_ready_held", 36'(rdy0), 36'd0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("bp_count", 36'(cnt0 - base0), 36'd3);
    chk("bp_q0_empty", 36'(q0.size()), 36'd0);

    // Back-to-back random stream with the consumer always ready
    repeat (6) tick();
    stall_cnt = 0;
    base0 = cnt0; base1 = cnt1; base2 = cnt2;
    gap0 = 0; gap1 = 0; gap2 = 0;
    for (int i = 0; i < 1000; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      if (!ov2) gap2++;
      if (i >= 1 && !ov0) gap0++;
      if (i >= 3 && !ov1) gap1++;
    end
    in_valid = 1'b0;
    repeat (6) tick();
    chk("tp_stalls", 36'(stall_cnt), 36'd0);
    chk("tp_gaps", 36'({gap0[7:0], gap1[7:0], gap2[7:0]}), 36'd0);
    chk("tp_count0", 36'(cnt0 - base0), 36'd1000);
    chk("tp_count1", 36'(cnt1 - base1), 36'd1000);
    chk("tp_count2", 36'(cnt2 - base2), 36'd1000);

    // Random valid/ready on both sides
    for (int i = 0; i < 600; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      a_in = $urandom; b_in = $urandom;
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("rnd_drained", 36'({q0.size(), q1.size(), q2.size()} != 0), 36'd0);

    // Reset mid-flight with two transactions inside
    drive($urandom, $urandom, 1'b0, 1'b0);
    tick();
    drive($urandom, $urandom, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("mr_pre_valid", 36'(ov0), 36'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid_drop", 36'({ov0, ov1, ov2}), 36'd0);
    chk("mr_flags0", {z0, o0, c0, 32'(s0)}, 36'd0);
    chk("mr_flags1", {z1, o1, c1, s1}, 36'd0);
    chk("mr_flags2", {z2, o2, c2, 32'(s2)}, 36'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      a_in = $urandom; b_in = $urandom;
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      tick();
      if (ov0 || ov1 || ov2) stale++;
    end
    chk("mr_no_stale", 36'(stale), 36'd0);
    chk("mr_in_ready", 36'({rdy0, rdy1, rdy2}), 36'h7);

    // Pipe still works after the mid-flight reset
    drive(32'd127, 32'd1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_rst_res", {ov0, z0, o0, c0, 32'(s0)}, {1'b1, 3'b010, 32'd128});
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
